// File: rtl/w_ptr_full_gen.sv
// Write-domain pointer and flag generator for the asynchronous FIFO.
// Full, almost-full and occupancy are registered from the next-state pointer so they never lag a write.
module w_ptr_full_gen #(
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6
) (
    input  logic              wr_clk,
    input  logic              wr_rst,
    input  logic              wr_en,
    input  logic              ovf_clr,
    input  logic [ADDR_W:0]   wq2_rptr,
    output logic              wr_ack,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   wr_ptr,
    output logic [ADDR_W:0]   wr_level
);

    localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W + 1)'(AF_LEVEL);

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_nx;
    logic [ADDR_W:0] wgray_nx;
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] rptr_full;
    logic [ADDR_W:0] level_nx;
    logic            push;
    logic            full_nx;
    logic            almost_full_nx;

    // Bit i of the binary read pointer is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        rbin = '0;
        for (int unsigned i = 0; i <= ADDR_W; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    always_comb begin
        push           = wr_en & ~full;
        wbin_nx        = wbin + (ADDR_W + 1)'(push);
        wgray_nx       = wbin_nx ^ (wbin_nx >> 1);
        rptr_full      = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
        full_nx        = (wgray_nx == rptr_full);
        level_nx       = wbin_nx - rbin;
        almost_full_nx = (level_nx >= AF_THRESH);
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wbin        <= '0;
            wr_ptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
            wr_ack      <= 1'b0;
        end else begin
            wbin        <= wbin_nx;
            wr_ptr      <= wgray_nx;
            full        <= full_nx;
            almost_full <= almost_full_nx;
            wr_level    <= level_nx;
            // A clear in the same cycle as an overflowing request wins.
            overflow    <= ovf_clr ? 1'b0 : (overflow | (wr_en & full));
            wr_ack      <= push;
        end
    end

    assign wr_addr = wbin[ADDR_W-1:0];

endmodule
